apb_arbiter: RTL and testbench



---
 rtl/apb_arbiter.sv | 126 ++++++++++++
 tb/tb_apb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-initiator to one-target APB arbiter, round-robin, one whole transfer per grant.
// Latency: initiator setup to target setup is 1 cycle; 3-cycle minimum transfer; 1 idle bubble between target transfers.
// Backpressure: t_pready is forwarded to the granted initiator only; the other initiator waits with pready low.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   i0_* / i1_*                  APB target-side ports facing initiators (i0 = core, i1 = secondary)
//   t_*                          APB initiator-side port facing the fabric
module apb_arbiter #(
  parameter int ADDR_W = 34,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // initiator 0
  input  logic                i0_psel,
  input  logic                i0_penable,
  input  logic [ADDR_W-1:0]   i0_paddr,
  input  logic                i0_pwrite,
  input  logic [DATA_W-1:0]   i0_pwdata,
  input  logic [DATA_W/8-1:0] i0_pwstrb,
  output logic                i0_pready,
  output logic [DATA_W-1:0]   i0_prdata,
  output logic                i0_pslverr,
  // initiator 1
  input  logic                i1_psel,
  input  logic                i1_penable,
  input  logic [ADDR_W-1:0]   i1_paddr,
  input  logic                i1_pwrite,
  input  logic [DATA_W-1:0]   i1_pwdata,
  input  logic [DATA_W/8-1:0] i1_pwstrb,
  output logic                i1_pready,
  output logic [DATA_W-1:0]   i1_prdata,
  output logic                i1_pslverr,
  // target (fabric)
  output logic                t_psel,
  output logic                t_penable,
  output logic [ADDR_W-1:0]   t_paddr,
  output logic                t_pwrite,
  output logic [DATA_W-1:0]   t_pwdata,
  output logic [DATA_W/8-1:0] t_pwstrb,
  input  logic                t_pready,
  input  logic [DATA_W-1:0]   t_prdata,
  input  logic                t_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_grant;
  logic   w_grant_nxt;
  logic   r_last;
  logic   w_last_nxt;

  // Arbitration keys only on psel; penable is not needed to decide a grant.
  logic w_unused;
  assign w_unused = i0_penable ^ i1_penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;  // i0 wins the first tie after reset
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (i0_psel && i1_psel) begin
          w_grant_nxt = ~r_last;
          w_state_nxt = SETUP;
        end else if (i0_psel) begin
          w_grant_nxt = 1'b0;
          w_state_nxt = SETUP;
        end else if (i1_psel) begin
          w_grant_nxt = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (t_pready) begin
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // psel/penable are pure state decodes: no path from t_pready.
  assign t_psel    = (r_state != IDLE);
  assign t_penable = (r_state == ACCESS);

  // Request payload follows the grant register even in IDLE; fabric ignores it while psel is low.
  assign t_paddr  = r_grant ? i1_paddr  : i0_paddr;
  assign t_pwrite = r_grant ? i1_pwrite : i0_pwrite;
  assign t_pwdata = r_grant ? i1_pwdata : i0_pwdata;
  assign t_pwstrb = r_grant ? i1_pwstrb : i0_pwstrb;

  logic w_resp0;
  logic w_resp1;
  assign w_resp0 = (r_state == ACCESS) && !r_grant;
  assign w_resp1 = (r_state == ACCESS) &&  r_grant;

  assign i0_pready  = w_resp0 & t_pready;
  assign i0_prdata  = w_resp0 ? t_prdata : '0;
  assign i0_pslverr = w_resp0 & t_pslverr;
  assign i1_pready  = w_resp1 & t_pready;
  assign i1_prdata  = w_resp1 ? t_prdata : '0;
  assign i1_pslverr = w_resp1 & t_pslverr;

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;
  localparam int ADDR_W = 34;
  localparam int DATA_W = 32;

  logic                clk;
  logic                rst_n;
  logic                i0_psel, i0_penable, i0_pwrite;
  logic [ADDR_W-1:0]   i0_paddr;
  logic [DATA_W-1:0]   i0_pwdata;
  logic [DATA_W/8-1:0] i0_pwstrb;
  logic                i0_pready, i0_pslverr;
  logic [DATA_W-1:0]   i0_prdata;
  logic                i1_psel, i1_penable, i1_pwrite;
  logic [ADDR_W-1:0]   i1_paddr;
  logic [DATA_W-1:0]   i1_pwdata;
  logic [DATA_W/8-1:0] i1_pwstrb;
  logic                i1_pready, i1_pslverr;
  logic [DATA_W-1:0]   i1_prdata;
  logic                t_psel, t_penable, t_pwrite;
  logic [ADDR_W-1:0]   t_paddr;
  logic [DATA_W-1:0]   t_pwdata;
  logic [DATA_W/8-1:0] t_pwstrb;
  logic                t_pready, t_pslverr;
  logic [DATA_W-1:0]   t_prdata;

  int n_assert = 0;
  int n_fail   = 0;

  apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_psel(i0_psel), .i0_penable(i0_penable), .i0_paddr(i0_paddr), .i0_pwrite(i0_pwrite),
    .i0_pwdata(i0_pwdata), .i0_pwstrb(i0_pwstrb), .i0_pready(i0_pready), .i0_prdata(i0_prdata),
    .i0_pslverr(i0_pslverr),
    .i1_psel(i1_psel), .i1_penable(i1_penable), .i1_paddr(i1_paddr), .i1_pwrite(i1_pwrite),
    .i1_pwdata(i1_pwdata), .i1_pwstrb(i1_pwstrb), .i1_pready(i1_pready), .i1_prdata(i1_prdata),
    .i1_pslverr(i1_pslverr),
    .t_psel(t_psel), .t_penable(t_penable), .t_paddr(t_paddr), .t_pwrite(t_pwrite),
    .t_pwdata(t_pwdata), .t_pwstrb(t_pwstrb), .t_pready(t_pready), .t_prdata(t_prdata),
    .t_pslverr(t_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n_grant;
    int n0;
    int n1;
    int n_pen;
    logic exp_g;

    rst_n = 1'b0;
    i0_psel = 0; i0_penable = 0; i0_pwrite = 0; i0_paddr = '0; i0_pwdata = '0; i0_pwstrb = '0;
    i1_psel = 0; i1_penable = 0; i1_pwrite = 0; i1_paddr = '0; i1_pwdata = '0; i1_pwstrb = '0;
    t_pready = 0; t_prdata = '0; t_pslverr = 0;

    // ---- reset state: drive a live target response to prove the gating
    tick();
    t_pready = 1; t_prdata = 32'hFFFF_FFFF; t_pslverr = 1; i0_psel = 1; i1_psel = 1;
    settle();
    chk("rst_t_psel",      t_psel,     0);
    chk("rst_t_penable",   t_penable,  0);
    chk("rst_i0_pready",   i0_pready,  0);
    chk("rst_i1_pready",   i1_pready,  0);
    chk("rst_i0_prdata",   i0_prdata,  0);
    chk("rst_i1_prdata",   i1_prdata,  0);
    chk("rst_i0_pslverr",  i0_pslverr, 0);
    chk("rst_i1_pslverr",  i1_pslverr, 0);
    i0_psel = 0; i1_psel = 0; t_pslverr = 0;
    tick();
    rst_n = 1'b1;

    // ---- 1: single i0 read, zero wait states
    tick();
    i0_psel = 1; i0_penable = 0; i0_paddr = 34'h0_8000_0000; i0_pwrite = 0;
    t_pready = 1; t_prdata = 32'hDEAD_BEEF;
    settle();
    chk("t1_idle_psel", t_psel, 0);
    tick();
    i0_penable = 1;
    settle();
    chk("t1_setup_psel",    t_psel,    1);
    chk("t1_setup_penable", t_penable, 0);
    chk("t1_setup_paddr",   t_paddr,   34'h0_8000_0000);
    chk("t1_setup_pwrite",  t_pwrite,  0);
    chk("t1_setup_i0rdy",   i0_pready, 0);
    tick();
    settle();
    chk("t1_acc_penable", t_penable, 1);
    chk("t1_acc_i0rdy",   i0_pready, 1);
    chk("t1_acc_i0rdata", i0_prdata, 32'hDEAD_BEEF);
    chk("t1_acc_i1rdy",   i1_pready, 0);
    chk("t1_acc_i1rdata", i1_prdata, 0);
    i0_psel = 0; i0_penable = 0;
    tick();
    settle();
    chk("t1_done_psel",  t_psel,    0);
    chk("t1_done_i0rdy", i0_pready, 0);

    // ---- 2: both request right after reset; 6 transfers each alternate 0,1,0,1...
    do_reset();
    i0_paddr = 34'h100; i1_paddr = 34'h200;
    i0_psel = 1; i1_psel = 1; t_pready = 1; t_prdata = 32'h0;
    n_grant = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 60 && n_grant < 12; c++) begin
      tick();
      settle();
      if (i0_pready || i1_pready) begin
        exp_g = (n_grant < 11) ? n_grant[0] : 1'b1;
        chk("t2_one_grant", {i0_pready, i1_pready}, exp_g ? 2'b01 : 2'b10);
        chk("t2_paddr", t_paddr, exp_g ? 34'h200 : 34'h100);
        if (i0_pready) n0++;
        if (i1_pready) n1++;
        n_grant++;
        if (n0 == 6) i0_psel = 0;
        if (n1 == 6) i1_psel = 0;
      end
    end
    chk("t2_total_grants", n_grant, 12);
    chk("t2_i0_grants", n0, 6);
    chk("t2_i1_grants", n1, 6);
    i0_psel = 0; i1_psel = 0;
    tick();
    tick();

    // ---- 3: i1 write with 3 wait states
    i1_psel = 1; i1_pwrite = 1; i1_pwdata = 32'h1234_5678; i1_pwstrb = 4'h3; i1_paddr = 34'h3_0000_0040;
    i0_pwdata = 32'hAAAA_AAAA; i0_pwstrb = 4'hF;
    t_pready = 0;
    tick();
    settle();
    chk("t3_setup_psel",    t_psel,    1);
    chk("t3_setup_penable", t_penable, 0);
    chk("t3_setup_pwdata",  t_pwdata,  32'h1234_5678);
    chk("t3_setup_pwrite",  t_pwrite,  1);
    n_pen = 0;
    for (int w = 0; w < 3; w++) begin
      tick();
      settle();
      if (t_penable) n_pen++;
      chk("t3_wait_i1rdy",  i1_pready, 0);
      chk("t3_wait_pwdata", t_pwdata,  32'h1234_5678);
      chk("t3_wait_pwstrb", t_pwstrb,  4'h3);
    end
    tick();
    t_pready = 1;
    settle();
    if (t_penable) n_pen++;
    chk("t3_last_i1rdy",  i1_pready, 1);
    chk("t3_last_pwstrb", t_pwstrb,  4'h3);
    chk("t3_last_i0rdy",  i0_pready, 0);
    i1_psel = 0;
    tick();
    settle();
    chk("t3_penable_cycles", n_pen, 4);
    chk("t3_done_penable",   t_penable, 0);

    // ---- 4: slave error on i0
    i0_psel = 1; i0_paddr = 34'h44; t_pready = 1; t_pslverr = 1;
    settle();
    chk("t4_idle_i0err", i0_pslverr, 0);
    tick();
    settle();
    chk("t4_setup_i0err", i0_pslverr, 0);
    chk("t4_setup_i1err", i1_pslverr, 0);
    tick();
    settle();
    chk("t4_acc_i0err", i0_pslverr, 1);
    chk("t4_acc_i0rdy", i0_pready,  1);
    chk("t4_acc_i1err", i1_pslverr, 0);
    i0_psel = 0;
    tick();
    settle();
    chk("t4_done_i0err", i0_pslverr, 0);
    chk("t4_done_i1err", i1_pslverr, 0);
    t_pslverr = 0;
    tick();

    // ---- 5: four back-to-back i0 reads, one bubble between target transfers
    i0_psel = 1; i0_pwrite = 0; t_pready = 1;
    n0 = 0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) tick();
      settle();
      chk("t5_psel_pattern", t_psel, (c % 3) != 0 && c < 12);
      chk("t5_i1rdy", i1_pready, 0);
      if (i0_pready) begin
        n0++;
        if (n0 == 4) i0_psel = 0;
      end
    end
    chk("t5_i0_grants", n0, 4);

    // ---- 6: reset during a stalled ACCESS, then tie goes to i0
    tick();
    i0_psel = 1; i0_paddr = 34'h66; t_pready = 0;
    tick();
    tick();
    settle();
    chk("t6_in_access", t_penable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_psel",    t_psel,    0);
    chk("t6_async_penable", t_penable, 0);
    i1_psel = 1; i1_paddr = 34'h77; t_pready = 1;
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    chk("t6_setup_psel",  t_psel,  1);
    chk("t6_setup_paddr", t_paddr, 34'h66);
    tick();
    settle();
    chk("t6_acc_i0rdy", i0_pready, 1);
    chk("t6_acc_i1rdy", i1_pready, 0);
    i0_psel = 0; i1_psel = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
